// File: rtl/feedback_scorer.sv
// Sequential Mastermind scoring engine.
// On a start pulse it latches the secret code and the guess. It then counts
// exact (black) matches, one position per clock, and colour-only (white)
// matches, one (guess, code) pair per clock. Finally it publishes the
// feedback digits and counts, and tracks turns and the win/lose state.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start                      pulse: score the current guess (honoured in IDLE only)
//   new_game                   pulse: clear turns/outputs and return to IDLE
//   code0..3, guess0..3        secret and guess pegs, COLOR_W bits each
//   fb0..fb3                   feedback digits: 0 none, 1 white, 2 black
//   exact_cnt, partial_cnt     black/white counts of the last scored guess
//   turns_used                 guesses scored this game (saturates at 15)
//   busy                       scoring in progress
//   done                       one-cycle pulse when the outputs update
//   win, lose, game_over       sticky game result flags
module feedback_scorer #(
    parameter int unsigned COLOR_W   = 3,
    parameter int unsigned MAX_TURNS = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               new_game,
    input  logic [COLOR_W-1:0] code0,
    input  logic [COLOR_W-1:0] code1,
    input  logic [COLOR_W-1:0] code2,
    input  logic [COLOR_W-1:0] code3,
    input  logic [COLOR_W-1:0] guess0,
    input  logic [COLOR_W-1:0] guess1,
    input  logic [COLOR_W-1:0] guess2,
    input  logic [COLOR_W-1:0] guess3,
    output logic [1:0]         fb0,
    output logic [1:0]         fb1,
    output logic [1:0]         fb2,
    output logic [1:0]         fb3,
    output logic [2:0]         exact_cnt,
    output logic [2:0]         partial_cnt,
    output logic [3:0]         turns_used,
    output logic               busy,
    output logic               done,
    output logic               win,
    output logic               lose,
    output logic               game_over
);

    localparam int unsigned PEGS    = 4;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned TURN_W  = 4;
    localparam int unsigned STEP_W  = 4;
    localparam int unsigned FB_W    = 2;

    localparam logic [FB_W-1:0]   FB_NONE  = 2'd0;
    localparam logic [FB_W-1:0]   FB_WHITE = 2'd1;
    localparam logic [FB_W-1:0]   FB_BLACK = 2'd2;
    localparam logic [TURN_W-1:0] TURN_SAT = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXACT   = 3'd1,
        S_PARTIAL = 3'd2,
        S_RESULT  = 3'd3,
        S_OVER    = 3'd4
    } state_e;

    state_e                          state_q, state_d;
    logic [STEP_W-1:0]               step_q, step_d;
    logic [PEGS-1:0][COLOR_W-1:0]    code_q, code_d;
    logic [PEGS-1:0][COLOR_W-1:0]    guess_q, guess_d;
    logic [PEGS-1:0]                 g_used_q, g_used_d;
    logic [PEGS-1:0]                 c_used_q, c_used_d;
    logic [CNT_W-1:0]                exact_q, exact_d;
    logic [CNT_W-1:0]                partial_q, partial_d;
    logic [CNT_W-1:0]                exact_cnt_q, exact_cnt_d;
    logic [CNT_W-1:0]                partial_cnt_q, partial_cnt_d;
    logic [PEGS-1:0][FB_W-1:0]       fb_q, fb_d;
    logic [TURN_W-1:0]               turns_q, turns_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            win_q, win_d;
    logic                            lose_q, lose_d;
    logic                            game_over_q, game_over_d;

    // Step counter decode: EXACT uses the low two bits as the position,
    // PARTIAL uses {i, j} with i (guess) as the outer index.
    logic [1:0] pos_i, pos_j;
    assign pos_i = step_q[3:2];
    assign pos_j = step_q[1:0];

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            step_q        <= '0;
            code_q        <= '0;
            guess_q       <= '0;
            g_used_q      <= '0;
            c_used_q      <= '0;
            exact_q       <= '0;
            partial_q     <= '0;
            exact_cnt_q   <= '0;
            partial_cnt_q <= '0;
            fb_q          <= '0;
            turns_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            win_q         <= 1'b0;
            lose_q        <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            code_q        <= code_d;
            guess_q       <= guess_d;
            g_used_q      <= g_used_d;
            c_used_q      <= c_used_d;
            exact_q       <= exact_d;
            partial_q     <= partial_d;
            exact_cnt_q   <= exact_cnt_d;
            partial_cnt_q <= partial_cnt_d;
            fb_q          <= fb_d;
            turns_q       <= turns_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            win_q         <= win_d;
            lose_q        <= lose_d;
            game_over_q   <= game_over_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        code_d        = code_q;
        guess_d       = guess_q;
        g_used_d      = g_used_q;
        c_used_d      = c_used_q;
        exact_d       = exact_q;
        partial_d     = partial_q;
        exact_cnt_d   = exact_cnt_q;
        partial_cnt_d = partial_cnt_q;
        fb_d          = fb_q;
        turns_d       = turns_q;
        win_d         = win_q;
        lose_d        = lose_q;
        done_d        = 1'b0;

        if (new_game) begin
            // Aborts any scoring in progress and takes priority over start
            state_d       = S_IDLE;
            step_d        = '0;
            exact_cnt_d   = '0;
            partial_cnt_d = '0;
            fb_d          = '0;
            turns_d       = '0;
            win_d         = 1'b0;
            lose_d        = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        code_d    = {code3, code2, code1, code0};
                        guess_d   = {guess3, guess2, guess1, guess0};
                        g_used_d  = '0;
                        c_used_d  = '0;
                        exact_d   = '0;
                        partial_d = '0;
                        step_d    = '0;
                        state_d   = S_EXACT;
                    end
                end

                S_EXACT: begin
                    if (guess_q[pos_j] == code_q[pos_j]) begin
                        exact_d          = exact_q + CNT_W'(1);
                        g_used_d[pos_j]  = 1'b1;
                        c_used_d[pos_j]  = 1'b1;
                    end
                    if (pos_j == 2'd3) begin
                        step_d  = '0;
                        state_d = S_PARTIAL;
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end

                S_PARTIAL: begin
                    // Used flags consumed by earlier pairs block double counting
                    if (!g_used_q[pos_i] && !c_used_q[pos_j]
                        && (guess_q[pos_i] == code_q[pos_j])) begin
                        partial_d        = partial_q + CNT_W'(1);
                        g_used_d[pos_i]  = 1'b1;
                        c_used_d[pos_j]  = 1'b1;
                    end
                    if (step_q == STEP_W'(15)) begin
                        step_d  = '0;
                        state_d = S_RESULT;
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end

                S_RESULT: begin
                    exact_cnt_d   = exact_q;
                    partial_cnt_d = partial_q;
                    for (int k = 0; k < PEGS; k++) begin
                        if (CNT_W'(k) < exact_q) begin
                            fb_d[k] = FB_BLACK;
                        end else if (CNT_W'(k) < (exact_q + partial_q)) begin
                            fb_d[k] = FB_WHITE;
                        end else begin
                            fb_d[k] = FB_NONE;
                        end
                    end
                    done_d  = 1'b1;
                    turns_d = (turns_q == TURN_SAT) ? TURN_SAT : turns_q + TURN_W'(1);
                    if (exact_q == CNT_W'(PEGS)) begin
                        win_d   = 1'b1;
                        state_d = S_OVER;
                    end else if ((5'(turns_q) + 5'd1) == 5'(MAX_TURNS)) begin
                        lose_d  = 1'b1;
                        state_d = S_OVER;
                    end else begin
                        state_d = S_IDLE;
                    end
                end

                S_OVER: begin
                    // Results held; only new_game leaves this state
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d      = (state_d == S_EXACT) || (state_d == S_PARTIAL) || (state_d == S_RESULT);
        game_over_d = win_d | lose_d;
    end

    assign fb0         = fb_q[0];
    assign fb1         = fb_q[1];
    assign fb2         = fb_q[2];
    assign fb3         = fb_q[3];
    assign exact_cnt   = exact_cnt_q;
    assign partial_cnt = partial_cnt_q;
    assign turns_used  = turns_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign win         = win_q;
    assign lose        = lose_q;
    assign game_over   = game_over_q;

endmodule
